// File: rtl/parallax_scroll_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : parallax_scroll_engine
// Purpose  : N-layer parallax scroller; composites layer ROMs into VRAM.
// Revision : 1.0
// ============================================================================
module parallax_scroll_engine #(
    parameter int                 NUM_LAYERS    = 3,
    parameter int                 LAYER_WIDTH   = 296,
    parameter int                 LAYER_HEIGHT  = 120,
    parameter int                 BUFFER_WIDTH  = 160,
    parameter int                 BUFFER_HEIGHT = 120,
    parameter int                 PIXEL_W       = 8,
    parameter logic [PIXEL_W-1:0] TRANSPARENT   = 8'h00,
    parameter logic [PIXEL_W-1:0] BG_COLOR      = 8'hc9,
    parameter int                 TICK_BITS     = 17,
    parameter int                 CFG_W         = 8,
    localparam int                LAYER_L       = LAYER_WIDTH * LAYER_HEIGHT,
    localparam int                VRAM_L        = BUFFER_WIDTH * BUFFER_HEIGHT,
    localparam int                LA_W          = $clog2(LAYER_L),
    localparam int                VA_W          = $clog2(VRAM_L),
    localparam int                OFF_W         = $clog2(LAYER_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic                            move_valid,
    input  logic                            move_dir,
    input  logic [NUM_LAYERS*CFG_W-1:0]     layer_speed,
    input  logic [NUM_LAYERS*CFG_W-1:0]     layer_period,
    output logic [NUM_LAYERS*LA_W-1:0]      layer_rd_addr,
    input  logic [NUM_LAYERS*PIXEL_W-1:0]   layer_rd_data,
    output logic                            vram_wr_ena,
    output logic [VA_W-1:0]                 vram_wr_addr,
    output logic [PIXEL_W-1:0]              vram_wr_data,
    output logic [NUM_LAYERS*OFF_W-1:0]     layer_offset,
    output logic                            busy,
    output logic                            frame_done
);

    localparam logic [LA_W:0]   LAYER_L_X = (LA_W+1)'(LAYER_L);
    localparam logic [OFF_W:0]  LAYER_W_X = (OFF_W+1)'(LAYER_WIDTH);
    localparam logic [VA_W-1:0] LAST_PIX  = VA_W'(VRAM_L - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state_q;
    logic [VA_W-1:0]      pix_q;
    logic                 wr_ena_q;
    logic [VA_W-1:0]      wr_addr_q;
    logic                 done_q;
    logic [TICK_BITS-1:0] tick_q;
    logic                 tick;
    logic [PIXEL_W-1:0]   pix_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_BITS'(1);
        end
    end

    assign tick = (tick_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_ena_q <= (state_q == FILL);
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ena) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    pix_q   <= '0;
                    state_q <= FILL;
                end
                FILL: begin
                    wr_addr_q <= pix_q;
                    pix_q     <= pix_q + VA_W'(1);
                    if (pix_q == LAST_PIX) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        logic [CFG_W-1:0] spd;
        logic [CFG_W-1:0] per;
        logic [CFG_W-1:0] cnt_q;
        logic [OFF_W-1:0] spd_red;
        logic [OFF_W-1:0] off_q;
        logic [OFF_W-1:0] off_d;
        logic [OFF_W-1:0] fwd;
        logic [OFF_W-1:0] bwd;
        logic [OFF_W:0]   sum;
        logic [LA_W-1:0]  addr_q;
        logic [LA_W-1:0]  base;
        logic [LA_W:0]    inc;

        assign spd     = layer_speed[i*CFG_W +: CFG_W];
        assign per     = layer_period[i*CFG_W +: CFG_W];
        assign spd_red = OFF_W'(32'(spd) % LAYER_WIDTH);

        // Both directions stay in [0, LAYER_WIDTH) without a signed modulo.
        assign sum   = {1'b0, off_q} + {1'b0, spd_red};
        assign fwd   = (sum >= LAYER_W_X) ? OFF_W'(sum - LAYER_W_X) : OFF_W'(sum);
        assign bwd   = (off_q < spd_red)
                     ? OFF_W'({1'b0, off_q} + LAYER_W_X - {1'b0, spd_red})
                     : off_q - spd_red;
        assign off_d = move_dir ? fwd : bwd;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                off_q <= '0;
                cnt_q <= '0;
            end else if (tick && move_valid && (per != '0)) begin
                if (cnt_q >= per - CFG_W'(1)) begin
                    cnt_q <= '0;
                    off_q <= off_d;
                end else begin
                    cnt_q <= cnt_q + CFG_W'(1);
                end
            end
        end

        // The running address latched at LOAD is the frame's shadow offset;
        // later offset steps never reach it until the next LOAD.
        assign base = LA_W'(32'(off_q) * LAYER_HEIGHT);
        assign inc  = {1'b0, addr_q} + (LA_W+1)'(1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                addr_q <= '0;
            end else if (state_q == LOAD) begin
                addr_q <= base;
            end else if (state_q == FILL) begin
                addr_q <= (inc >= LAYER_L_X) ? LA_W'(inc - LAYER_L_X) : LA_W'(inc);
            end
        end

        assign layer_rd_addr[i*LA_W +: LA_W]  = addr_q;
        assign layer_offset[i*OFF_W +: OFF_W] = off_q;
    end

    always_comb begin
        pix_d = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_rd_data[i*PIXEL_W +: PIXEL_W] != TRANSPARENT) begin
                pix_d = layer_rd_data[i*PIXEL_W +: PIXEL_W];
            end
        end
    end

    assign vram_wr_ena  = wr_ena_q;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_ena_q ? pix_d : '0;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_parallax_scroll_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_parallax_scroll_engine
// Purpose  : Directed self-checking bench for parallax_scroll_engine.
// Revision : 1.0
// ============================================================================
module tb_parallax_scroll_engine;

    localparam int LAYER_L = 35520;
    localparam int VRAM_L  = 19200;
    localparam int NV      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        move_valid;
    logic        move_dir;
    logic [23:0] layer_speed;
    logic [23:0] layer_period;
    logic [47:0] layer_rd_addr;
    logic [23:0] layer_rd_data;
    logic        vram_wr_ena;
    logic [14:0] vram_wr_addr;
    logic [7:0]  vram_wr_data;
    logic [26:0] layer_offset;
    logic        busy;
    logic        frame_done;

    logic [7:0]  rom_q [3];
    logic        ovr_en;
    logic [23:0] ovr_data;
    int          mode;
    int          ntests = 0;
    int          nfail  = 0;

    typedef struct {
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] l2;
        logic [7:0] expv;
    } vec_t;
    vec_t tbl [NV];

    parallax_scroll_engine #(.TICK_BITS(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .move_valid    (move_valid),
        .move_dir      (move_dir),
        .layer_speed   (layer_speed),
        .layer_period  (layer_period),
        .layer_rd_addr (layer_rd_addr),
        .layer_rd_data (layer_rd_data),
        .vram_wr_ena   (vram_wr_ena),
        .vram_wr_addr  (vram_wr_addr),
        .vram_wr_data  (vram_wr_data),
        .layer_offset  (layer_offset),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] romf(input int m, input int i, input int a);
        logic [7:0] v;
        v = 8'h00;
        case (m)
            0: v = 8'(a & 255);
            1: begin
                if (i == 0 && (a % 4) == 0)       v = 8'hA5;
                if (i == 1 && (a % 2) == 1)       v = 8'h5A;
                if (i == 2 && ((a / 2) % 2) == 1) v = 8'h33;
            end
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] expc(input int m, input int j, input int b0, input int b1, input int b2);
        int b [3];
        logic [7:0] v;
        b[0] = b0; b[1] = b1; b[2] = b2;
        for (int i = 0; i < 3; i++) begin
            v = romf(m, i, (b[i] + j) % LAYER_L);
            if (v != 8'h00) return v;
        end
        return 8'hc9;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rom_q[i] <= romf(mode, i, int'(layer_rd_addr[i*16 +: 16]));
        end
    end

    assign layer_rd_data = ovr_en ? ovr_data : {rom_q[2], rom_q[1], rom_q[0]};

    task automatic chk(input string nm, input int act, input int expv);
        ntests++;
        if (act != expv) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_offs(input string nm, input int o0, input int o1, input int o2);
        chk({nm, "_off0"}, int'(layer_offset[0 +: 9]),  o0);
        chk({nm, "_off1"}, int'(layer_offset[9 +: 9]),  o1);
        chk({nm, "_off2"}, int'(layer_offset[18 +: 9]), o2);
    endtask

    task automatic set_cfg(input int s0, input int s1, input int s2,
                           input int p0, input int p1, input int p2);
        layer_speed  = {8'(s2), 8'(s1), 8'(s0)};
        layer_period = {8'(p2), 8'(p1), 8'(p0)};
    endtask

    task automatic mv_window(input int n);
        @(negedge clk);
        move_valid = 1'b1;
        repeat (n) @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic run_frame(input int m, input int o0, input int o1, input int o2,
                             input int mv_start, input int mv_len, input int abort_k,
                             input bit tbl_en,
                             output int r0, output int r119, output int r120);
        int  b [3];
        int  nw, addr_err, data_err, rd_err, busy_err;
        int  done_cnt, done_k, last_wr_k, stray, ex;
        bit  aborted, tslot;
        b[0] = o0 * 120; b[1] = o1 * 120; b[2] = o2 * 120;
        nw = 0; addr_err = 0; data_err = 0; rd_err = 0; busy_err = 0;
        done_cnt = 0; done_k = -1; last_wr_k = -1; aborted = 1'b0;
        r0 = -1; r119 = -1; r120 = -1;
        mode = m;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        chk("load_busy", int'(busy), 1);
        for (int k = 0; k < VRAM_L + 10 && !aborted; k++) begin
            @(negedge clk);
            tslot = tbl_en && k >= 100 && k < 100 + NV;
            if (tslot) begin
                ovr_data = {tbl[k-100].l2, tbl[k-100].l1, tbl[k-100].l0};
                ovr_en   = 1'b1;
                #1;
                chk($sformatf("composite_vec%0d", k - 100), int'(vram_wr_data), int'(tbl[k-100].expv));
                ovr_en   = 1'b0;
            end
            if (k == mv_start) move_valid = 1'b1;
            if (k == mv_start + mv_len) move_valid = 1'b0;
            if (vram_wr_ena) begin
                if (int'(vram_wr_addr) != nw) addr_err++;
                if (!tslot && vram_wr_data != expc(m, nw, b[0], b[1], b[2])) data_err++;
                last_wr_k = k;
                nw++;
            end
            if (frame_done) begin
                done_cnt++;
                done_k = k;
            end
            if (k < VRAM_L) begin
                for (int i = 0; i < 3; i++) begin
                    ex = (b[i] + k) % LAYER_L;
                    if (int'(layer_rd_addr[i*16 +: 16]) != ex) rd_err++;
                end
                if (k == 0)   r0   = int'(layer_rd_addr[15:0]);
                if (k == 119) r119 = int'(layer_rd_addr[15:0]);
                if (k == 120) r120 = int'(layer_rd_addr[15:0]);
            end
            if (busy != (k <= VRAM_L)) busy_err++;
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk("abort_wr_ena", int'(vram_wr_ena), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_frame_done", int'(frame_done), 0);
                stray = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (vram_wr_ena || frame_done || busy) stray++;
                end
                rst = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    if (vram_wr_ena || frame_done || busy) stray++;
                end
                chk("abort_quiet", stray, 0);
                aborted = 1'b1;
            end
        end
        chk("write_count", nw, aborted ? abort_k : VRAM_L);
        chk("write_addr_order_errors", addr_err, 0);
        chk("write_data_errors", data_err, 0);
        chk("rd_addr_errors", rd_err, 0);
        chk("busy_errors", busy_err, 0);
        if (abort_k < 0) begin
            chk("frame_done_count", done_cnt, 1);
            chk("last_write_cycle", last_wr_k, VRAM_L);
            chk("frame_done_cycle", done_k, VRAM_L + 1);
        end else begin
            chk("abort_no_frame_done", done_cnt, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r119, r120;
        tbl[0] = '{8'h00, 8'h00, 8'h00, 8'hc9};
        tbl[1] = '{8'h00, 8'h5A, 8'h33, 8'h5A};
        tbl[2] = '{8'h00, 8'h00, 8'h33, 8'h33};
        tbl[3] = '{8'h11, 8'h5A, 8'h33, 8'h11};
        tbl[4] = '{8'h00, 8'h5A, 8'h00, 8'h5A};
        tbl[5] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        tbl[6] = '{8'h00, 8'h00, 8'h01, 8'h01};
        tbl[7] = '{8'h80, 8'h00, 8'h7F, 8'h80};

        rst = 1'b1; ena = 1'b0; move_valid = 1'b0; move_dir = 1'b1;
        ovr_en = 1'b0; ovr_data = '0; mode = 0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_wr_ena", int'(vram_wr_ena), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_wr_addr", int'(vram_wr_addr), 0);
        chk("rst_wr_data", int'(vram_wr_data), 0);
        chk("rst_rd_addr", int'(layer_rd_addr[15:0]), 0);
        chk_offs("rst", 0, 0, 0);
        rst = 1'b0;

        run_frame(0, 0, 0, 0, -1, 0, -1, 1'b0, r0, r119, r120);
        chk("frameA_rd0_first", r0, 0);
        chk("frameA_rd0_k120", r120, 120);

        move_dir = 1'b1; set_cfg(1, 0, 0, 1, 0, 0);
        mv_window(4);
        chk_offs("step_to_1", 1, 0, 0);
        move_dir = 1'b0; set_cfg(3, 0, 0, 1, 0, 0);
        mv_window(4);
        chk_offs("neg_wrap", 294, 0, 0);
        mv_window(4);
        chk_offs("neg_again", 291, 0, 0);
        move_dir = 1'b1; set_cfg(1, 10, 200, 4, 2, 1);
        mv_window(32);
        chk_offs("periods_8ticks", 293, 40, 120);
        set_cfg(1, 10, 200, 0, 0, 0);
        mv_window(32);
        chk_offs("period_zero", 293, 40, 120);
        set_cfg(1, 10, 200, 4, 2, 1);
        repeat (32) @(negedge clk);
        chk_offs("move_invalid", 293, 40, 120);
        set_cfg(2, 10, 200, 1, 0, 0);
        mv_window(4);
        chk_offs("to_295", 295, 40, 120);

        run_frame(1, 295, 40, 120, 10, 400, -1, 1'b0, r0, r119, r120);
        chk("frameB_rd0_first", r0, 35400);
        chk("frameB_rd0_k119", r119, 35519);
        chk("frameB_rd0_k120", r120, 0);
        chk_offs("live_after_frameB", 199, 40, 120);

        run_frame(2, 199, 40, 120, -1, 0, 5000, 1'b1, r0, r119, r120);
        chk("frameC_rd0_first", r0, 23880);
        chk_offs("after_abort", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
